// File: rtl/accel_arbiter_if.sv
// Request/response bundle between N requesters and one accelerator slave port.
// slave is the arbiter's view; master is the requester/accelerator side.
interface accel_arbiter_if #(
    parameter int N  = 4,
    parameter int PW = 104
);
    logic [N-1:0]    req_access;
    logic [N*PW-1:0] req_packet;
    logic [N-1:0]    req_wait;
    logic            acc_access;
    logic [PW-1:0]   acc_packet;
    logic            acc_wait;
    logic            acc_rr_access;
    logic [PW-1:0]   acc_rr_packet;
    logic            acc_rr_wait;
    logic [N-1:0]    rsp_access;
    logic [PW-1:0]   rsp_packet;
    logic [N-1:0]    rsp_wait;

    modport slave (
        input  req_access, req_packet,
        output req_wait,
        output acc_access, acc_packet,
        input  acc_wait,
        input  acc_rr_access, acc_rr_packet,
        output acc_rr_wait,
        output rsp_access, rsp_packet,
        input  rsp_wait
    );

    modport master (
        output req_access, req_packet,
        input  req_wait,
        input  acc_access, acc_packet,
        output acc_wait,
        output acc_rr_access, acc_rr_packet,
        input  acc_rr_wait,
        input  rsp_access, rsp_packet,
        output rsp_wait
    );
endinterface

// File: rtl/accel_arbiter.sv
// Round-robin N:1 accelerator arbiter with in-order read-response routing.
// Define ACCEL_ARB_STATS_EN to enable saturating per-requester grant counters.
module accel_arbiter #(
    parameter int N     = 4,
    parameter int AW    = 32,
    parameter int PW    = 2*AW+40,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            nreset,
    accel_arbiter_if.slave  bus,
    output logic            err_orphan,
    output logic [N*16-1:0] grant_count
);
    localparam int TW   = (N > 1) ? $clog2(N) : 1;
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = PTRW + 1;

    logic            acc_access_q;
    logic [PW-1:0]   acc_packet_q;
    logic [TW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   tag_mem_q [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            err_q;

    logic            free, fifo_full, fifo_empty;
    logic            grant, push, pop;
    logic [N-1:0]    elig;
    logic [N-1:0]    rsp_d;
    logic [TW-1:0]   gidx;
    logic [TW-1:0]   head;
    logic [PW-1:0]   gpkt;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign free       = !acc_access_q || !bus.acc_wait;

    // Reads are only eligible while a tag slot is available.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = bus.req_access[i] &&
                      (bus.req_packet[i*PW] || !fifo_full);
        end
    end

    always_comb begin : rr_pick
        int idx;
        idx   = 0;
        grant = 1'b0;
        gidx  = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!grant && free && elig[idx]) begin
                grant = 1'b1;
                gidx  = TW'(idx);
            end
        end
    end

    assign gpkt  = bus.req_packet[int'(gidx)*PW +: PW];
    assign ptr_d = grant ? TW'((int'(gidx) + 1) % N) : ptr_q;
    assign push  = grant && !gpkt[0];

    always_comb begin
        bus.req_wait = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_wait[i] = bus.req_access[i] &&
                              !(grant && gidx == TW'(i));
        end
    end

    assign head = tag_mem_q[rd_ptr_q];
    assign pop  = bus.acc_rr_access && !fifo_empty && !bus.rsp_wait[head];

    always_comb begin
        rsp_d = '0;
        if (bus.acc_rr_access && !fifo_empty) begin
            rsp_d[head] = 1'b1;
        end
    end

    assign bus.rsp_access  = rsp_d;
    assign bus.rsp_packet  = bus.acc_rr_packet;
    assign bus.acc_rr_wait = !fifo_empty && bus.rsp_wait[head];
    assign bus.acc_access  = acc_access_q;
    assign bus.acc_packet  = acc_packet_q;
    assign err_orphan      = err_q;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            acc_access_q <= 1'b0;
            ptr_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (free) begin
                acc_access_q <= grant;
            end
            ptr_q <= ptr_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (bus.acc_rr_access && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: it is qualified by acc_access / count.
    always_ff @(posedge clk) begin
        if (grant) begin
            acc_packet_q <= gpkt;
        end
        if (push) begin
            tag_mem_q[wr_ptr_q] <= gidx;
        end
    end

`ifdef ACCEL_ARB_STATS_EN
    logic [15:0] cnt_q [N];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (grant && cnt_q[gidx] != 16'hFFFF) begin
            cnt_q[gidx] <= cnt_q[gidx] + 16'd1;
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < N; i++) begin
            grant_count[i*16 +: 16] = cnt_q[i];
        end
    end
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_accel_arbiter.sv
// Randomized bench for accel_arbiter against a queue-based reference model.
// Phases: write rotation, read backpressure, random mix, acc stalls, orphans, reset.
module tb_accel_arbiter;
    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int PW    = 2*AW+40;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            err_orphan;
    logic [N*16-1:0] grant_count;

    always #5 clk = ~clk;

    accel_arbiter_if #(.N(N), .PW(PW)) bus ();

    accel_arbiter #(
        .N(N), .AW(AW), .PW(PW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bus),
        .err_orphan(err_orphan),
        .grant_count(grant_count)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit            m_acc;
    logic [PW-1:0] m_pkt;
    int            m_p;
    int            tagq[$];
    bit            m_err;
    int            m_cnt[N];

    task automatic model_reset();
        m_acc = 1'b0;
        m_p   = 0;
        tagq.delete();
        m_err = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    function automatic logic [PW-1:0] rand_pkt(input bit wr);
        logic [127:0] r;
        logic [PW-1:0] p;
        r = {$urandom, $urandom, $urandom, $urandom};
        p = r[PW-1:0];
        p[0] = wr;
        return p;
    endfunction

    task automatic drive(input int preq, input int pread, input int pwait,
                         input int prr, input int prsw);
        for (int i = 0; i < N; i++) begin
            bus.req_access[i] = ($urandom_range(99) < preq);
            bus.req_packet[i*PW +: PW] =
                rand_pkt(!($urandom_range(99) < pread));
            bus.rsp_wait[i] = ($urandom_range(99) < prsw);
        end
        bus.acc_wait      = ($urandom_range(99) < pwait);
        bus.acc_rr_access = ($urandom_range(99) < prr);
        bus.acc_rr_packet = rand_pkt($urandom_range(1));
    endtask

    task automatic step_check();
        bit            free;
        bit            pop;
        int            g;
        int            idx;
        logic [N-1:0]  exp_wait;
        logic [N-1:0]  exp_rsp;
        logic [N*16-1:0] exp_cnt;

        free = !m_acc || !bus.acc_wait;
        g = -1;
        if (free) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_p + k) % N;
                if (g < 0 && bus.req_access[idx] &&
                    (bus.req_packet[idx*PW] || tagq.size() < DEPTH))
                    g = idx;
            end
        end

        exp_wait = bus.req_access;
        if (g >= 0) exp_wait[g] = 1'b0;
        check("req_wait", bus.req_wait & bus.req_access, exp_wait);
        check("acc_access", bus.acc_access, m_acc);
        if (m_acc) check("acc_packet", bus.acc_packet, m_pkt);

        exp_rsp = '0;
        pop = 1'b0;
        if (bus.acc_rr_access) begin
            if (tagq.size() > 0) begin
                exp_rsp[tagq[0]] = 1'b1;
                check("rsp_packet", bus.rsp_packet, bus.acc_rr_packet);
                check("acc_rr_wait", bus.acc_rr_wait, bus.rsp_wait[tagq[0]]);
                pop = !bus.rsp_wait[tagq[0]];
            end else begin
                check("acc_rr_wait_empty", bus.acc_rr_wait, 1'b0);
            end
        end
        check("rsp_access", bus.rsp_access, exp_rsp);
        check("err_orphan", err_orphan, m_err);

        exp_cnt = '0;
`ifdef ACCEL_ARB_STATS_EN
        for (int i = 0; i < N; i++) exp_cnt[i*16 +: 16] = 16'(m_cnt[i]);
`endif
        check("grant_count", grant_count, exp_cnt);

        if (!nreset) begin
            model_reset();
        end else begin
            if (bus.acc_rr_access && tagq.size() == 0) m_err = 1'b1;
            if (pop) void'(tagq.pop_front());
            if (g >= 0) begin
                if (!bus.req_packet[g*PW]) tagq.push_back(g);
                if (m_cnt[g] < 16'hFFFF) m_cnt[g]++;
                m_pkt = bus.req_packet[g*PW +: PW];
                m_p = (g + 1) % N;
            end
            if (free) m_acc = (g >= 0);
        end
    endtask

    task automatic run(input int n, input bit rst, input int preq,
                       input int pread, input int pwait,
                       input int prr, input int prsw);
        repeat (n) begin
            @(posedge clk);
            #1;
            nreset = !rst;
            drive(preq, pread, pwait, prr, prsw);
            @(negedge clk);
            step_check();
        end
    endtask

    initial begin
        bus.req_access    = '0;
        bus.req_packet    = '0;
        bus.acc_wait      = 1'b0;
        bus.acc_rr_access = 1'b0;
        bus.acc_rr_packet = '0;
        bus.rsp_wait      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;

        run(40,  1'b0, 100,  0,  0,   0,  0);
        run(200, 1'b0,  60, 80, 10,  40, 85);
        run(600, 1'b0,  50, 40, 25,  40, 30);
        run(150, 1'b0,  70, 30, 70,  30, 20);
        run(30,  1'b0,   0,  0,  0, 100,  0);
        run(2,   1'b1,  60, 50, 20,  30, 30);
        run(300, 1'b0,  60, 50, 20,  35, 30);
        run(60,  1'b0, 100,  0,  0,   0,  0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/accel_arbiter.md
ACCEL_ARBITER -- requirements
Module: accel_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the accelerator slave port (2..8).
REQ-002 Parameter AW, default 32: native address width.
REQ-003 Parameter PW, default 2*AW+40: emesh packet width.
REQ-004 Parameter DEPTH, default 4: read-tag FIFO depth (power of 2).
REQ-005 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-006 nreset  in  1  reset; one clock; reset is synchronous and active-low.
REQ-007 req_access  in  N  per-requester packet valid.
REQ-008 req_packet  in  N*PW  per-requester emesh packet; requester i at bits [i*PW +: PW].
REQ-009 req_wait  out  N  per-requester stall.
REQ-010 acc_access  out  1  packet valid toward accelerator slave port.
REQ-011 acc_packet  out  PW  granted packet.
REQ-012 acc_wait  in  1  accelerator stall.
REQ-013 acc_rr_access  in  1  read-response valid from accelerator.
REQ-014 acc_rr_packet  in  PW  read-response packet.
REQ-015 acc_rr_wait  out  1  read-response stall toward accelerator.
REQ-016 rsp_access  out  N  one-hot read-response valid per requester.
REQ-017 rsp_packet  out  PW  response packet, broadcast to all requesters.
REQ-018 rsp_wait  in  N  per-requester response stall.
REQ-019 err_orphan  out  1  sticky flag: response received with no outstanding read.
REQ-020 grant_count  out  N*16  per-requester grant counters (see Configuration).

Function
REQ-021 Packet bit 0 SHALL be the write flag; write=0 denotes a read request.
REQ-022 The output stage SHALL be a single register (acc_access, acc_packet); it is "free" when acc_access=0 or acc_wait=0.
REQ-023 When the output stage is free, the arbiter SHALL grant exactly one eligible requester, loading its packet so acc_access=1 on the next cycle (latency 1).
REQ-024 Eligible: req_access[i]=1, and if the packet is a read, the tag FIFO is not full.
REQ-025 Priority SHALL be round-robin: search starts at pointer P, after a grant to i then P=(i+1) mod N; P unchanged when no grant.
REQ-026 req_wait[i] SHALL be 0 only in the cycle requester i is granted; otherwise 1 whenever req_access[i]=1.
REQ-027 While acc_wait=1 and acc_access=1, acc_packet SHALL hold stable and no grant occurs.
REQ-028 Each granted read SHALL push the requester index into the tag FIFO in the grant cycle.
REQ-029 Responses return in order: when acc_rr_access=1 and FIFO non-empty, rsp_access SHALL be one-hot at head tag, rsp_packet=acc_rr_packet, acc_rr_wait=rsp_wait[head], combinationally.
REQ-030 FIFO SHALL pop when acc_rr_access=1 and acc_rr_wait=0; simultaneous push and pop in one cycle SHALL leave occupancy unchanged.
REQ-031 Response with FIFO empty: acc_rr_wait=0, rsp_access=0, packet dropped, err_orphan set to 1 next cycle and held.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH.

Reset
REQ-033 nreset=0 SHALL clear acc_access, P (to 0), FIFO occupancy and pointers, err_orphan, and all grant_count fields to 0.
REQ-034 Reset mid-transfer SHALL discard the output register content and all outstanding tags; acc_packet value is don't-care while acc_access=0.

Configuration
REQ-035 Macro ACCEL_ARB_STATS_EN defined: each grant_count field SHALL increment by 1 per grant to that requester, saturating at 16'hFFFF.
REQ-036 Macro ACCEL_ARB_STATS_EN undefined: grant_count SHALL be constant 0 and no counter logic SHALL be present; port list unchanged.

Verification
REQ-037 All N requesters write continuously, acc_wait=0 -> grants rotate 0,1,2,3,0,...; each req_wait low once per 4 cycles.
REQ-038 Requester 2 issues read to output register -> acc_access next cycle; response one cycle later routed with rsp_access=4'b0100.
REQ-039 Requester 1 issues 5 back-to-back reads with responses stalled -> 4 granted, 5th held with req_wait[1]=1 until one pop; writes from requester 0 still granted meanwhile.
REQ-040 acc_wait=1 for 3 cycles with acc_access=1 -> acc_packet unchanged, all req_wait=1, P unchanged; grant resumes on release.
REQ-041 acc_rr_access=1 with empty FIFO -> acc_rr_wait=0, rsp_access=0, err_orphan=1 next cycle, cleared only by nreset=0.
REQ-042 With ACCEL_ARB_STATS_EN, 10 grants to requester 3 -> grant_count[63:48]=10; without macro -> 0.
